// File: rtl/mul_div_unit_if.sv
// Decoded mul/div operation type and the issue/result interface between decode and the HI/LO unit.
// The master side issues operations; the slave side (the unit) returns busy/done and the 64-bit result.
package mul_div_pkg;
    typedef enum logic [2:0] {
        OpClr   = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4
    } mult_t;
endpackage

interface mul_div_if;
    import mul_div_pkg::*;

    logic        start;
    mult_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO unit: fixed-latency multiply, 32-step restoring divide with sign fix-up.
// Stalls via busy while in flight and pulses done for one cycle as hi/lo take the new result.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic      clk,
    input  logic      reset,
    mul_div_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } state_t;

    localparam logic [5:0] MulLast = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DivLast = 6'd31;

    state_t      r_state;
    state_t      w_state_next;
    mult_t       r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_mul_sx;
    logic [63:0] w_ax;
    logic [63:0] w_bx;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic        w_div_signed;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_new_signed;

    assign w_accept = bus.start && (bus.op != OpClr) && !bus.flush
                      && ((r_state == StIdle) || (r_state == StDone));
    assign w_is_mul = (bus.op == OpMult) || (bus.op == OpMultu);

    // Low 64 bits of a 64x64 product equal the true product once operands are extended correctly.
    assign w_mul_sx = (r_op == OpMult);
    assign w_ax     = {{32{w_mul_sx & r_a[31]}}, r_a};
    assign w_bx     = {{32{w_mul_sx & r_b[31]}}, r_b};
    assign w_prod   = w_ax * w_bx;

    // One restoring step: shift next dividend bit into the partial remainder and try to subtract.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = !w_diff[32];

    assign w_div_signed = (r_op == OpDiv);
    assign w_quo_fix    = (w_div_signed && (r_a[31] ^ r_b[31])) ? -r_quo : r_quo;
    assign w_rem_fix    = (w_div_signed && r_a[31]) ? -r_rem : r_rem;
    assign w_new_signed = (bus.op == OpDiv);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        w_state_next = w_is_mul ? StMul : StDiv;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
                StMul:   if (r_cnt == MulLast) w_state_next = StDone;
                StDiv:   if (r_cnt == DivLast) w_state_next = StFix;
                StFix:   w_state_next = StDone;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op  <= OpClr;
            r_a   <= '0;
            r_b   <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.op;
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_cnt <= '0;
                r_rem <= '0;
                r_quo <= (w_new_signed && bus.a[31]) ? -bus.a : bus.a;
                r_div <= (w_new_signed && bus.b[31]) ? -bus.b : bus.b;
            end else if (r_state == StMul) begin
                r_cnt <= r_cnt + 6'd1;
            end else if (r_state == StDiv) begin
                r_cnt <= r_cnt + 6'd1;
                r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
                r_quo <= {r_quo[30:0], w_ge};
            end

            // Only the edge entering DONE writes hi/lo; a flush can never reach DONE.
            if (w_state_next == StDone) begin
                if (r_state == StFix) begin
                    if (r_b == 32'd0) begin
                        r_hi <= r_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end else begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end
            end
        end
    end

    assign bus.busy = (r_state == StMul) || (r_state == StDiv) || (r_state == StFix);
    assign bus.done = (r_state == StDone);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle HI/LO arithmetic unit in the execute stage, directly downstream of the decode control logic.
- Consumes the decoded multiply/divide control (MULT, MULTU, DIV, DIVU, CLR) and the forwarded rs/rt operands.
- Stalls the pipeline while an operation is in flight, then presents the 64-bit result as hi/lo with a one-cycle done pulse.
- The HI/LO register write logic captures hi/lo on done.

Parameters:
MUL_CYCLES, 2, number of busy cycles for MULT/MULTU (legal range 1..8)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  issue request, sampled each cycle
op  in  mult_t  decoded operation: CLR, MULT, MULTU, DIV, DIVU
a  in  32  rs operand (dividend / multiplicand)
b  in  32  rt operand (divisor / multiplier)
flush  in  1  abort any in-flight operation
busy  out  1  operation in flight; pipeline stall request
done  out  1  one-cycle pulse; hi/lo hold the new result this cycle
hi  out  32  product[63:32] or remainder
lo  out  32  product[31:0] or quotient

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers cleared.
  - Reset asserted mid-operation discards the operation. No done is produced.
- States:
  - IDLE, MUL, DIV, FIX, DONE.
  - busy=1 exactly in MUL, DIV and FIX.
  - done=1 exactly in DONE.
- Accept condition: start=1 and op!=CLR and state is IDLE or DONE and flush=0.
  - Operands and op are latched at the accepting edge (cycle T).
  - start with op=CLR is ignored.
  - start while busy is ignored. Upstream holds the instruction via the stall.
- MULT/MULTU:
  - MUL for MUL_CYCLES cycles (T+1..T+MUL_CYCLES), then DONE at T+MUL_CYCLES+1.
  - Full 64-bit product: signed×signed for MULT, unsigned×unsigned for MULTU.
- DIV/DIVU, restoring radix-2 on 32-bit magnitudes:
  - DIV takes absolute values of a and b. DIVU uses a and b raw.
  - DIV state for 32 cycles (T+1..T+32), one quotient bit per cycle, with a 6-bit iteration counter.
  - FIX at T+33 applies sign correction:
    - quotient negated if a[31]^b[31] (DIV only);
    - remainder negated if a[31] (DIV only).
  - DONE at T+34.
- Signed division semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b==0), DIV or DIVU:
  - Same latency as a normal divide.
  - hi=a, lo=0xFFFFFFFF.
  - No sign correction.
- hi/lo update only at the edge entering DONE. They hold their value at all other times, including across flush.
- DONE lasts one cycle, then IDLE. A new accept in DONE goes directly to MUL/DIV, so a back-to-back issue loses no cycle.
- flush=1 in any state:
  - next state IDLE, done=0 next cycle, hi/lo unchanged;
  - flush wins over a simultaneous start;
  - flush arriving during DONE still leaves that cycle's done=1 visible (already registered).

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, hi=lo=0 throughout.
- MULT a=0xFFFFFFFF b=2, then MULTU same operands, back-to-back from DONE -> first done at T+3: hi=0xFFFFFFFF lo=0xFFFFFFFE. Second done 3 cycles later: hi=0x00000001 lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy T+1..T+33, done at T+34: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234 b=0 -> hi=0x1234, lo=0xFFFFFFFF, done at T+34.
- Start DIVU, assert flush at T+10 with start=1 -> IDLE at T+11, no done, hi/lo keep prior values. Start accepted at T+11 completes normally.
- Start DIV, assert reset asynchronously mid-cycle at T+5 -> busy drops immediately, hi=lo=0. After release, the next MULTU 3×5 gives lo=15, hi=0.
